// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family.
package fifo_pkg;

    // Default geometry and thresholds
    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned FIFO_AF_DEF    = FIFO_DEPTH_DEF - 2;
    localparam int unsigned FIFO_AE_DEF    = 2;

    // Read-mode selectors
    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Pointer width: address bits plus one wrap bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem_dp #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [Width-1:0] rd_data_o
);

    logic [Width-1:0] mem_q [Depth];

    // Storage is intentionally not reset; occupancy tracking makes stale words unobservable
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Asynchronous read port
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill count, thresholds, sticky errors and selectable read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned Width   = FIFO_WIDTH_DEF,
    parameter int unsigned Depth   = FIFO_DEPTH_DEF,
    parameter int unsigned AFLevel = Depth - 2,
    parameter int unsigned AELevel = FIFO_AE_DEF,
    parameter int unsigned FWFT    = FWFT_OFF,
    localparam int unsigned PW     = ptr_width(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] DataI,
    input  logic             W,
    input  logic             R,
    input  logic             ClrErr,
    output logic [Width-1:0] DataO,
    output logic             FF,
    output logic             EF,
    output logic             AF,
    output logic             AE,
    output logic [PW-1:0]    Count,
    output logic             OVF,
    output logic             UDF
);

    localparam int unsigned    AW       = PW - 1;
    localparam logic [PW-1:0]  DEPTH_LV = PW'(Depth);
    localparam logic [PW-1:0]  AF_LV    = PW'(AFLevel);
    localparam logic [PW-1:0]  AE_LV    = PW'(AELevel);
    localparam logic           AF_RST   = (AFLevel == 0);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q,  count_d;
    logic             ff_q, ff_d;
    logic             ef_q, ef_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wa, ra;
    logic [Width-1:0] rd_word;

    // Accept decisions: a write at full is allowed only when a read frees the slot
    always_comb begin
        wa = W && (!ff_q || R);
        ra = R && !ef_q;
    end

    // Next-state for pointers, occupancy, flags and sticky errors
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wa) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (ra) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + PW'(wa) - PW'(ra);

        // Flags are registered from the next count so they track Count on the same edge
        ff_d = (count_d == DEPTH_LV);
        ef_d = (count_d == '0);
        af_d = (count_d >= AF_LV);
        ae_d = (count_d <= AE_LV);

        // Set has priority over clear
        ovf_d = (W && ff_q && !R) || (ovf_q && !ClrErr);
        udf_d = (R && ef_q)       || (udf_q && !ClrErr);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ff_q     <= 1'b0;
            ef_q     <= 1'b1;
            af_q     <= AF_RST;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ff_q     <= ff_d;
            ef_q     <= ef_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem_dp #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wa),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (DataI),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_word)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Head word is presented directly; forced to zero while empty
            assign DataO = ef_q ? '0 : rd_word;
        end else begin : g_reg
            logic [Width-1:0] dout_q, dout_d;

            // Output word updates only on an accepted read
            always_comb begin
                dout_d = dout_q;
                if (ra) begin
                    dout_d = rd_word;
                end
            end

            // Registered read data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign DataO = dout_q;
        end
    endgenerate

    assign Count = count_q;
    assign FF    = ff_q;
    assign EF    = ef_q;
    assign AF    = af_q;
    assign AE    = ae_q;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;

endmodule
